// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit sigma-delta bitstream: ORDER integrators at the input
// rate, ORDER combs at the decimated rate, then scaling with saturation to OUT_W bits.
module cic_decimator #(
    parameter int ORDER      = 3,
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             new_data
);

    localparam int W  = ORDER * LOG2_DECIM + 1;
    localparam int SH = W - 1 - OUT_W;

    localparam logic [0:0] SETTLE = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    localparam logic [LOG2_DECIM-1:0] PHASE_LAST  = '1;
    localparam logic [2:0]            SETTLE_LAST = 3'(ORDER - 1);

    logic [W-1:0]            integ   [ORDER];
    logic [W-1:0]            dly     [ORDER];
    logic [W-1:0]            comb_in [ORDER];
    logic [W-1:0]            comb_out;
    logic [W-1:0]            shifted;
    logic [OUT_W-1:0]        sat;
    logic [LOG2_DECIM-1:0]   phase;
    logic [2:0]              settle_cnt;
    logic [0:0]              state;
    logic                    strobe;

    assign strobe = en && (phase == PHASE_LAST);

    // Comb chain is combinational so the result lands in data_out on the strobe edge itself.
    always_comb begin
        comb_out = integ[ORDER-1];
        for (int unsigned k = 0; k < ORDER; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - dly[k];
        end
    end

    // Only full scale (exactly 2^(W-1)) can reach the bit above OUT_W.
    assign shifted = comb_out >> SH;
    assign sat     = (|shifted[W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            phase      <= '0;
            settle_cnt <= '0;
            state      <= SETTLE;
            data_out   <= '0;
            new_data   <= 1'b0;
        end else begin
            new_data <= 1'b0;
            if (en) begin
                integ[0] <= integ[0] + {{(W-1){1'b0}}, data_in};
                for (int unsigned k = 1; k < ORDER; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                phase <= phase + 1'b1;
                if (strobe) begin
                    for (int unsigned k = 0; k < ORDER; k++) begin
                        dly[k] <= comb_in[k];
                    end
                    case (state)
                        SETTLE: begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state <= RUN;
                            end else begin
                                settle_cnt <= settle_cnt + 3'd1;
                            end
                        end
                        default: begin
                            data_out <= sat;
                            new_data <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Parameters
REQ-001 SHALL have parameter ORDER, default 3, number of integrator and comb stages (legal range 1..4).
REQ-002 SHALL have parameter LOG2_DECIM, default 6, giving decimation ratio DECIM = 2^LOG2_DECIM (legal range 1..8).
REQ-003 SHALL have parameter OUT_W, default 12, output word width; ORDER*LOG2_DECIM >= OUT_W is required.

Interface
REQ-004 SHALL have the single clock input clk, 1 bit, with all state updating on its rising edge.
REQ-005 SHALL have reset input rst_n, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have input en, 1 bit: sample enable; when low, the block holds all state.
REQ-007 SHALL have input data_in, 1 bit: modulator bitstream, where 1 adds 1 and 0 adds 0.
REQ-008 SHALL have output data_out, OUT_W bits, unsigned and registered: the decimated sample.
REQ-009 SHALL have output new_data, 1 bit, registered: a one-cycle pulse that marks a new data_out.

Function
REQ-010 SHALL use internal width W = ORDER*LOG2_DECIM + 1 for every integrator, comb and delay register; all adds and subtracts SHALL wrap modulo 2^W.
REQ-011 SHALL implement ORDER cascaded registered integrators on enabled edges: stage 1 += data_in; stage k += stage k-1 register value.
REQ-012 SHALL keep a LOG2_DECIM-bit phase counter that increments on each enabled edge and wraps from DECIM-1 to 0.
REQ-013 SHALL generate a decimation strobe on each enabled edge where the counter equals DECIM-1, i.e. on the n*DECIM-th enabled edge after reset.
REQ-014 On a strobe, SHALL compute ORDER cascaded comb stages y_k = x_k - x_k_delayed, with x_1 = last integrator register; on the same edge each delay register SHALL load its stage input.
REQ-015 SHALL scale the comb result R (range 0..2^(W-1)) as data_out = min(R >> (W-1-OUT_W), 2^OUT_W - 1); full scale SHALL saturate, never wrap to 0.
REQ-016 SHALL register data_out and assert new_data on the strobe edge, giving zero additional latency; new_data SHALL be low in all other cycles.
REQ-017 SHALL implement a two-state FSM, SETTLE -> RUN: SETTLE counts strobes and moves to RUN on the ORDER-th strobe; RUN is held until reset.
REQ-018 In SETTLE, the comb and delay registers SHALL update, new_data SHALL stay 0 and data_out SHALL stay 0; the first pulse SHALL occur on strobe ORDER+1.
REQ-019 With en low, the integrators, counter, comb, FSM and data_out SHALL hold, and new_data SHALL be 0 even if the counter equals DECIM-1.
REQ-020 Integrator wrap-around SHALL NOT corrupt the output; correctness follows from modulo-2^W arithmetic, and no overflow detection SHALL be added.
REQ-021 If en and a strobe coincide with rst_n low, reset SHALL win.

Reset
REQ-022 When rst_n is low at a clk edge, the integrators, delays, counter and settle count SHALL clear to 0, the FSM SHALL go to SETTLE, data_out SHALL be 0 and new_data SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all history; after release, behaviour SHALL be identical to that after power-up reset.
REQ-024 All stages SHALL share the single rst_n; no internal reset staggering SHALL be used.

Verification
REQ-025 Defaults, en=1, data_in constant 1 -> no pulse through edge 192; pulses at edges 256, 320, ... (64-cycle spacing), each with data_out = 4095.
REQ-026 Defaults, data_in constant 0 -> pulses at the same edges with data_out = 0; data_in alternating 1,0 -> steady-state data_out = 2048.
REQ-027 Defaults, data_in constant 1 for 2^20 cycles (forces integrator wrap) -> every data_out after settle remains 4095.
REQ-028 Defaults, en low for 37 cycles mid-frame -> no new_data and all outputs held; after en returns high, the next pulse arrives exactly 37 cycles later than it would have without the gap.
REQ-029 rst_n pulsed low for 1 cycle mid-frame during RUN -> data_out = 0 and new_data = 0 on the next edge, then a fresh settle with the first pulse 256 enabled edges after release.
REQ-030 The bench SHALL run ORDER=1, LOG2_DECIM=4, OUT_W=4 with constant 1 -> first pulse at edge 32, data_out = 15 (saturated), and with constant 0 -> data_out = 0.
